// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between writeback sources.
// Define REGF_CLEAR_EN to compile in the post-reset sweep that zeroes x1..x31.
module regfile_wb_arbiter #(
    parameter int REGF_WIDTH = 32,
    parameter int NUM_REQ    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [5*NUM_REQ-1:0]          req_rd,
    input  logic [REGF_WIDTH*NUM_REQ-1:0] req_data,
    output logic                          w_en,
    output logic [4:0]                    rd,
    output logic [REGF_WIDTH-1:0]         data_w,
    output logic [1:0]                    grant_id,
    output logic                          conflict,
    output logic                          busy
);

    typedef enum logic {ST_CLEAR, ST_ARB} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              ptr, ptr_nxt;
    logic [1:0]              sel, idx;
    logic                    found, dup, xfer;
    logic [4:0]              sel_rd;
    logic [REGF_WIDTH-1:0]   sel_data;

`ifdef REGF_CLEAR_EN
    logic [4:0]              clr_idx;
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_ARB;
`endif

    // Priority search starting at ptr, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 2'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_rd    = '0;
        sel_data  = '0;
        xfer      = found && rst_n && (state == ST_ARB);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == 2'(i)) begin
                req_ready[i] = xfer;
                sel_rd       = req_rd[i*5 +: 5];
                sel_data     = req_data[i*REGF_WIDTH +: REGF_WIDTH];
            end
        end
        ptr_nxt = (sel == 2'(NUM_REQ - 1)) ? 2'd0 : sel + 2'd1;
    end

    // Any pair of valid requesters aiming at the same live register, winner or not
    always_comb begin
        dup = 1'b0;
        for (int a = 0; a < NUM_REQ; a++) begin
            for (int b = a + 1; b < NUM_REQ; b++) begin
                if (req_valid[a] && req_valid[b] &&
                    req_rd[a*5 +: 5] == req_rd[b*5 +: 5] && req_rd[a*5 +: 5] != 5'd0)
                    dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
`ifdef REGF_CLEAR_EN
        if (state == ST_CLEAR && clr_idx == 5'd31)
            state_nxt = ST_ARB;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= RST_STATE;
        else
            state <= state_nxt;
    end

    assign busy = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_en     <= 1'b0;
            rd       <= '0;
            data_w   <= '0;
            grant_id <= '0;
            conflict <= 1'b0;
            ptr      <= '0;
`ifdef REGF_CLEAR_EN
            clr_idx  <= 5'd1;
`endif
        end else begin
            w_en     <= 1'b0;
            conflict <= 1'b0;
`ifdef REGF_CLEAR_EN
            if (state == ST_CLEAR) begin
                w_en    <= 1'b1;
                rd      <= clr_idx;
                data_w  <= '0;
                clr_idx <= clr_idx + 5'd1;
            end else
`endif
            if (xfer) begin
                // x0 writes complete the handshake but never reach the file
                w_en     <= (sel_rd != 5'd0);
                rd       <= sel_rd;
                data_w   <= sel_data;
                grant_id <= sel;
                ptr      <= ptr_nxt;
                conflict <= dup;
            end
        end
    end

endmodule
